// File: rtl/rvc_asap_imem_loader.sv
// Boot loader: Len-prefixed byte stream packed little-endian into I_MEM words; holds the core in reset until loaded.
// Write issued the cycle after a word's 4th byte or the last byte; RxReady stays high across word boundaries.
module rvc_asap_imem_loader #(
  parameter int IMEM_BYTES = 1024,
  parameter int ADDR_W     = 8
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              Start,
  input  logic              RxValid,
  input  logic [7:0]        RxData,
  output logic              RxReady,
  output logic              ImemWrEn,
  output logic [ADDR_W-1:0] ImemWrAddr,
  output logic [31:0]       ImemWrData,
  output logic [3:0]        ImemWrByteEn,
  output logic              CoreRst,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [31:0]       r_shadow;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_waddr;

  logic [2:0]  w_state_nxt;
  logic        w_accept;
  logic        w_start_ok;
  logic [15:0] w_len_full;
  logic [1:0]  w_lane;
  logic        w_last;
  logic        w_wr_fire;
  logic [31:0] w_merged_dat;
  logic [3:0]  w_merged_be;
  logic        w_rx_nxt;

  // RxReady is registered from the next state, so it already reflects the FSM position.
  assign w_accept     = RxValid && RxReady;
  assign w_start_ok   = Start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_len_full   = {RxData, r_len[7:0]};
  assign w_lane       = r_cnt[1:0];
  assign w_last       = ((r_cnt + 16'd1) == r_len);
  assign w_wr_fire    = (r_state == S_LOAD) && w_accept && (w_last || (w_lane == 2'd3));
  assign w_merged_dat = r_shadow | (32'(RxData) << {w_lane, 3'b000});
  assign w_merged_be  = r_be | (4'b0001 << w_lane);
  assign w_rx_nxt     = (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                        (w_state_nxt == S_LOAD);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_ok) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_accept) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len_full == 16'd0)
            w_state_nxt = S_DONE;
          else if ({1'b0, w_len_full} > 17'(IMEM_BYTES))
            w_state_nxt = S_ERROR;
          else
            w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_be         <= '0;
      r_waddr      <= '0;
      RxReady      <= 1'b0;
      ImemWrEn     <= 1'b0;
      ImemWrAddr   <= '0;
      ImemWrData   <= '0;
      ImemWrByteEn <= '0;
      CoreRst      <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      RxReady <= w_rx_nxt;
      Busy    <= w_rx_nxt;
      Done    <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      // Release the core only once DONE has been held a cycle, after the final write lands.
      CoreRst <= !((r_state == S_DONE) && (w_state_nxt == S_DONE));

      if (w_start_ok)
        Error <= 1'b0;
      else if (w_state_nxt == S_ERROR)
        Error <= 1'b1;

      if ((r_state == S_LEN_LO) && w_accept)
        r_len[7:0] <= RxData;

      if ((r_state == S_LEN_HI) && w_accept) begin
        r_len[15:8] <= RxData;
        r_cnt       <= '0;
        r_waddr     <= '0;
        r_shadow    <= '0;
        r_be        <= '0;
      end

      if ((r_state == S_LOAD) && w_accept) begin
        r_cnt <= r_cnt + 16'd1;
        if (w_wr_fire) begin
          r_shadow <= '0;
          r_be     <= '0;
          r_waddr  <= r_waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          r_shadow <= w_merged_dat;
          r_be     <= w_merged_be;
        end
      end

      ImemWrEn <= w_wr_fire;
      if (w_wr_fire) begin
        ImemWrAddr   <= r_waddr;
        ImemWrData   <= w_merged_dat;
        ImemWrByteEn <= w_merged_be;
      end else begin
        ImemWrAddr   <= '0;
        ImemWrData   <= '0;
        ImemWrByteEn <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rvc_asap_imem_loader.sv
// Scoreboard bench: expected I_MEM writes queued at stimulus time, popped by a negedge monitor.
module tb_rvc_asap_imem_loader;

  logic        Clock = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic        RxValid = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxReady;
  logic        ImemWrEn;
  logic [7:0]  ImemWrAddr;
  logic [31:0] ImemWrData;
  logic [3:0]  ImemWrByteEn;
  logic        CoreRst;
  logic        Busy;
  logic        Done;
  logic        Error;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] dat;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  rvc_asap_imem_loader #(.IMEM_BYTES(1024), .ADDR_W(8)) dut (
    .Clock(Clock), .Rst(Rst), .Start(Start), .RxValid(RxValid), .RxData(RxData),
    .RxReady(RxReady), .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr),
    .ImemWrData(ImemWrData), .ImemWrByteEn(ImemWrByteEn), .CoreRst(CoreRst),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (ImemWrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h be %h (t=%0t)",
                 ImemWrAddr, ImemWrData, ImemWrByteEn, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(ImemWrAddr), 32'(mon_e.addr));
        chk("wr_data", ImemWrData, mon_e.dat);
        chk("wr_be", 32'(ImemWrByteEn), 32'(mon_e.be));
      end
    end
  end

  task automatic exp_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back('{addr: a, dat: d, be: be});
  endtask

  task automatic do_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("rxready_after_start", 32'(RxReady), 32'd1);
    chk("busy_after_start", 32'(Busy), 32'd1);
    chk("corerst_after_start", 32'(CoreRst), 32'd1);
  endtask

  // Entered and left at a negedge; on return the byte has been accepted at the previous posedge.
  task automatic send(input logic [7:0] b, input int gap);
    int k;
    if (gap > 0) begin
      RxValid = 1'b0;
      repeat (gap) @(negedge Clock);
    end
    RxValid = 1'b1;
    RxData  = b;
    k = 0;
    while (!RxReady && k < 100) begin
      @(negedge Clock);
      k++;
    end
    if (!RxReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: RxReady %b expected 1 for byte %h", RxReady, b);
      RxValid = 1'b0;
      return;
    end
    @(negedge Clock);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    RxValid = 1'b0;
  endtask

  // Called at cycle N+1 after the final byte.
  task automatic check_done();
    chk("done_pulse", 32'(Done), 32'd1);
    chk("corerst_hold_n1", 32'(CoreRst), 32'd1);
    chk("rxready_done", 32'(RxReady), 32'd0);
    chk("busy_done", 32'(Busy), 32'd0);
    @(negedge Clock);
    chk("done_clear", 32'(Done), 32'd0);
    chk("corerst_release", 32'(CoreRst), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_corerst"}, 32'(CoreRst), 32'd1);
    chk({tag, "_rxready"}, 32'(RxReady), 32'd0);
    chk({tag, "_wren"}, 32'(ImemWrEn), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_error"}, 32'(Error), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge Clock);
    check_reset_vals("reset");
    Rst = 1'b1;
    repeat (2) @(negedge Clock);
    check_reset_vals("idle");

    // Two full words, back to back.
    exp_wr(8'd0, 32'h0050_0013, 4'hF);
    exp_wr(8'd1, 32'h0010_0093, 4'hF);
    do_start();
    send_stream('{8'h08, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00}, 0);
    check_done();

    // Partial final word from DONE (reload).
    exp_wr(8'd0, 32'h4433_2211, 4'hF);
    exp_wr(8'd1, 32'h0000_6655, 4'h3);
    do_start();
    send_stream('{8'h06, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 0);
    check_done();

    // Zero-length image.
    do_start();
    send_stream('{8'h00, 8'h00}, 0);
    check_done();

    // Oversize image.
    do_start();
    send_stream('{8'h01, 8'h04}, 0);
    chk("err_set", 32'(Error), 32'd1);
    chk("err_rxready", 32'(RxReady), 32'd0);
    chk("err_corerst", 32'(CoreRst), 32'd1);
    chk("err_done", 32'(Done), 32'd0);
    repeat (3) @(negedge Clock);
    chk("err_sticky", 32'(Error), 32'd1);
    exp_wr(8'd0, 32'hEFBE_ADDE, 4'hF);
    do_start();
    chk("err_cleared", 32'(Error), 32'd0);
    send_stream('{8'h04, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    check_done();

    // Same image as the first run, with random valid gaps.
    exp_wr(8'd0, 32'h0050_0013, 4'hF);
    exp_wr(8'd1, 32'h0010_0093, 4'hF);
    do_start();
    send_stream('{8'h08, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00}, 3);
    check_done();

    // Reset after five bytes: partial word discarded, no writes.
    do_start();
    send_stream('{8'h08, 8'h00, 8'h13, 8'h00, 8'h50}, 0);
    #2;
    Rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge Clock);
    Rst = 1'b1;
    repeat (5) @(negedge Clock);
    check_reset_vals("post_midrst");

    // Start and RxValid together in IDLE: byte must not be taken that cycle.
    Start   = 1'b1;
    RxValid = 1'b1;
    RxData  = 8'h04;
    chk("start_vs_valid_rxready", 32'(RxReady), 32'd0);
    @(negedge Clock);
    Start   = 1'b0;
    RxValid = 1'b0;
    chk("start_vs_valid_busy", 32'(Busy), 32'd1);
    exp_wr(8'd0, 32'h0302_0100, 4'hF);
    exp_wr(8'd1, 32'h0000_0004, 4'h1);
    send_stream('{8'h05, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
    check_done();

    repeat (4) @(negedge Clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
